// File: rtl/dram2buffer_input.sv
// rtl/dram2buffer_input.sv - stream-to-bank loader for the double-banked input buffer
//
// Accepts a valid/ready stream of DATA_W-bit words and writes them into one
// bank of the ping-pong input buffer. The words go to consecutive addresses,
// starting at the start address and ending at the end address, and the
// address wraps modulo 2**BUF_AW. A one-cycle load_done pulse follows the
// last committed write.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_start               one-cycle start request, sampled in IDLE only
//   BUF_ADDR_start           [BUF_AW] selects the bank, [BUF_AW-1:0] is the first address
//   BUF_ADDR_end             [BUF_AW-1:0] is the last address, [BUF_AW] is ignored
//   load_done                one-cycle pulse after the last word is written
//   busy                     high in LOAD, FLUSH and DONE
//   data_in / data_in_valid / data_in_ready   input word stream
//   input_buffer_DI[0:1]         per-bank write data
//   input_buffer_A_write[0:1]    per-bank write address
//   input_buffer_CEN_write[0:1]  per-bank chip enable, active-low
//   input_buffer_WEN[0:1]        per-bank write enable, active-low
module dram2buffer_input #(
  parameter int DATA_W = 32,
  parameter int BUF_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [BUF_AW:0]   BUF_ADDR_start,
  input  logic [BUF_AW:0]   BUF_ADDR_end,
  output logic              load_done,
  output logic              busy,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [DATA_W-1:0] input_buffer_DI        [0:1],
  output logic [BUF_AW-1:0] input_buffer_A_write   [0:1],
  output logic              input_buffer_CEN_write [0:1],
  output logic              input_buffer_WEN       [0:1]
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t              state_q;
  logic                bank_q;
  logic [BUF_AW-1:0]   addr_q;
  logic [BUF_AW-1:0]   addr_d;
  logic [BUF_AW-1:0]   end_q;
  logic [DATA_W-1:0]   di_q  [0:1];
  logic [BUF_AW-1:0]   a_q   [0:1];
  logic                cen_q [0:1];
  logic                wen_q [0:1];

  // Bank bit of the end address carries no meaning; the start address owns it.
  logic unused_end_bank;
  assign unused_end_bank = BUF_ADDR_end[BUF_AW];

  // Natural overflow of the BUF_AW-bit counter gives the 127 -> 0 wrap.
  assign addr_d = addr_q + BUF_AW'(1);

  assign data_in_ready = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign load_done     = (state_q == DONE);

  assign input_buffer_DI        = di_q;
  assign input_buffer_A_write   = a_q;
  assign input_buffer_CEN_write = cen_q;
  assign input_buffer_WEN       = wen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bank_q   <= 1'b0;
      addr_q   <= '0;
      end_q    <= '0;
      di_q[0]  <= '0;
      di_q[1]  <= '0;
      a_q[0]   <= '0;
      a_q[1]   <= '0;
      cen_q[0] <= 1'b1;
      cen_q[1] <= 1'b1;
      wen_q[0] <= 1'b1;
      wen_q[1] <= 1'b1;
    end else begin
      // Strobes last exactly one cycle; an accepted beat re-asserts them below.
      // A and DI are deliberately left holding their last values.
      cen_q[0] <= 1'b1;
      cen_q[1] <= 1'b1;
      wen_q[0] <= 1'b1;
      wen_q[1] <= 1'b1;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            bank_q  <= BUF_ADDR_start[BUF_AW];
            addr_q  <= BUF_ADDR_start[BUF_AW-1:0];
            end_q   <= BUF_ADDR_end[BUF_AW-1:0];
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (data_in_valid) begin
            di_q[bank_q]  <= data_in;
            a_q[bank_q]   <= addr_q;
            cen_q[bank_q] <= 1'b0;
            wen_q[bank_q] <= 1'b0;
            addr_q        <= addr_d;
            if (addr_q == end_q) begin
              state_q <= FLUSH;
            end
          end
        end
        // The final write strobe is on the bus during FLUSH.
        FLUSH:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram2buffer_input.sv
// tb/tb_dram2buffer_input.sv - directed self-checking bench for dram2buffer_input
module tb_dram2buffer_input;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  BUF_ADDR_start;
  logic [7:0]  BUF_ADDR_end;
  logic        load_done;
  logic        busy;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [31:0] di  [0:1];
  logic [6:0]  aw  [0:1];
  logic        cen [0:1];
  logic        wen [0:1];

  dram2buffer_input #(.DATA_W(32), .BUF_AW(7)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .load_start             (load_start),
    .BUF_ADDR_start         (BUF_ADDR_start),
    .BUF_ADDR_end           (BUF_ADDR_end),
    .load_done              (load_done),
    .busy                   (busy),
    .data_in                (data_in),
    .data_in_valid          (data_in_valid),
    .data_in_ready          (data_in_ready),
    .input_buffer_DI        (di),
    .input_buffer_A_write   (aw),
    .input_buffer_CEN_write (cen),
    .input_buffer_WEN       (wen)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: samples at negedge, only appends.
  int          cyc = 0;
  int          w_bank[$];
  int          w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          acc_cyc[$];
  int          done_cyc[$];
  int          ready_cnt = 0;
  int          busy_cnt  = 0;
  int          viol      = 0;
  logic        exp_bank  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!cen[b] || !wen[b]) begin
        if (b == int'(exp_bank)) begin
          w_bank.push_back(b);
          w_addr.push_back(int'(aw[b]));
          w_data.push_back(di[b]);
          w_cyc.push_back(cyc);
        end else begin
          viol++;
        end
      end
    end
    if (data_in_ready && data_in_valid) acc_cyc.push_back(cyc);
    if (load_done) done_cyc.push_back(cyc);
    if (data_in_ready) ready_cnt++;
    if (busy) busy_cnt++;
  end

  int w0, a0, d0, r0, b0, v0;

  task automatic snap(input logic bank);
    exp_bank = bank;
    w0 = w_addr.size();
    a0 = acc_cyc.size();
    d0 = done_cyc.size();
    r0 = ready_cnt;
    b0 = busy_cnt;
    v0 = viol;
  endtask

  // Issues one load and feeds the stream until busy falls. Outside LOAD the
  // bench offers junk with valid high, and pulses load_start during DONE.
  task automatic run_load(input logic [7:0] st, input logic [7:0] en, input bit toggle,
                          input logic [31:0] base, input bit repulse, input int abort_after);
    int k     = 0;
    int beats = 0;
    bit v;
    bit fin   = 1'b0;
    load_start     = 1'b1;
    BUF_ADDR_start = st;
    BUF_ADDR_end   = en;
    data_in_valid  = 1'b1;
    data_in        = 32'hDEAD_0000;
    @(posedge clk); #1;
    load_start     = 1'b0;
    BUF_ADDR_start = 8'hFF;
    BUF_ADDR_end   = 8'hFF;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (abort_after != 0 && beats == abort_after) begin
        rst           = 1'b1;
        data_in_valid = 1'b0;
        fin           = 1'b1;
      end else if (data_in_ready) begin
        v = toggle ? (k % 2 == 0) : 1'b1;
        k++;
        data_in_valid = v;
        data_in       = v ? base + beats : 32'h0000_0BAD;
        if (v) beats++;
        load_start = repulse && (k == 2);
        if (load_start) begin
          BUF_ADDR_start = 8'h9F;
          BUF_ADDR_end   = 8'h9F;
        end
      end else if (!busy) begin
        load_start    = 1'b0;
        data_in_valid = 1'b0;
        fin           = 1'b1;
      end else begin
        data_in_valid = 1'b1;
        data_in       = 32'hDEAD_BEEF;
        load_start    = load_done;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    check("load_finished", 32'(fin), 32'd1);
    load_start    = 1'b0;
    data_in_valid = 1'b0;
  endtask

  // addrs holds the expected write addresses, one per byte, first at [7:0].
  task automatic verify(input string tag, input logic bank, input int n,
                        input logic [63:0] addrs, input logic [31:0] base);
    int nw = w_addr.size() - w0;
    int na = acc_cyc.size() - a0;
    int nd = done_cyc.size() - d0;
    check({tag, "_writes"}, nw, n);
    check({tag, "_accepts"}, na, n);
    if (nw == n && na == n) begin
      for (int i = 0; i < n; i++) begin
        check({tag, "_bank"}, w_bank[w0+i], 32'(bank));
        check({tag, "_addr"}, w_addr[w0+i], 32'(addrs[i*8 +: 8]));
        check({tag, "_data"}, w_data[w0+i], base + i);
        check({tag, "_wr_lat"}, w_cyc[w0+i] - acc_cyc[a0+i], 1);
      end
    end
    check({tag, "_dones"}, nd, 1);
    if (nd == 1 && na == n && n > 0) check({tag, "_done_lat"}, done_cyc[d0] - acc_cyc[a0+n-1], 2);
    check({tag, "_other_bank"}, viol - v0, 0);
  endtask

  initial begin
    rst            = 1'b1;
    load_start     = 1'b0;
    BUF_ADDR_start = 8'h00;
    BUF_ADDR_end   = 8'h00;
    data_in        = 32'h0;
    data_in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cen0", 32'(cen[0]), 1);
    check("rst_cen1", 32'(cen[1]), 1);
    check("rst_wen0", 32'(wen[0]), 1);
    check("rst_wen1", 32'(wen[1]), 1);
    check("rst_a0", 32'(aw[0]), 0);
    check("rst_di1", di[1], 0);
    check("rst_ready", 32'(data_in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(load_done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bank 0 basic
    snap(1'b0);
    run_load(8'h00, 8'h03, 1'b0, 32'hA0, 1'b0, 0);
    verify("b0", 1'b0, 4, {32'h0, 8'd3, 8'd2, 8'd1, 8'd0}, 32'hA0);
    check("b0_ready_cycles", ready_cnt - r0, 4);
    check("b0_busy_cycles", busy_cnt - b0, 6);
    check("b0_hold_a", 32'(aw[0]), 3);
    check("b0_hold_di", di[0], 32'hA3);
    check("b0_a1_untouched", 32'(aw[1]), 0);
    @(posedge clk); #1;
    check("b0_idle_after", 32'(busy), 0);

    // Bank 1 with bubbles
    snap(1'b1);
    run_load(8'h8A, 8'h8C, 1'b1, 32'hB0, 1'b0, 0);
    verify("b1", 1'b1, 3, {40'h0, 8'd12, 8'd11, 8'd10}, 32'hB0);
    check("b1_ready_cycles", ready_cnt - r0, 5);
    check("b1_busy_cycles", busy_cnt - b0, 7);

    // Wrap 126 -> 1
    snap(1'b0);
    run_load(8'h7E, 8'h01, 1'b0, 32'h70, 1'b0, 0);
    verify("wrap", 1'b0, 4, {32'h0, 8'd1, 8'd0, 8'd127, 8'd126}, 32'h70);
    check("wrap_ready_cycles", ready_cnt - r0, 4);

    // Single word
    snap(1'b0);
    run_load(8'h05, 8'h05, 1'b0, 32'h55, 1'b0, 0);
    verify("single", 1'b0, 1, {56'h0, 8'd5}, 32'h55);
    check("single_ready_cycles", ready_cnt - r0, 1);
    check("single_busy_cycles", busy_cnt - b0, 3);

    // load_start re-pulsed mid-load must not relatch
    snap(1'b0);
    run_load(8'h10, 8'h13, 1'b0, 32'hE0, 1'b1, 0);
    verify("repulse", 1'b0, 4, {32'h0, 8'h13, 8'h12, 8'h11, 8'h10}, 32'hE0);

    // Reset after 2 of 8 beats
    snap(1'b0);
    run_load(8'h20, 8'h27, 1'b0, 32'hF0, 1'b0, 2);
    @(posedge clk); #1;
    check("abort_writes", w_addr.size() - w0, 2);
    if (w_addr.size() - w0 == 2) begin
      check("abort_addr0", w_addr[w0], 32'h20);
      check("abort_addr1", w_addr[w0+1], 32'h21);
    end
    check("abort_cen0", 32'(cen[0]), 1);
    check("abort_cen1", 32'(cen[1]), 1);
    check("abort_wen0", 32'(wen[0]), 1);
    check("abort_wen1", 32'(wen[1]), 1);
    check("abort_ready", 32'(data_in_ready), 0);
    check("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cyc.size() - d0, 0);
    check("abort_still_idle", 32'(busy), 0);

    // Fresh load after the reset
    snap(1'b1);
    run_load(8'h83, 8'h84, 1'b0, 32'hC0, 1'b0, 0);
    verify("after", 1'b1, 2, {48'h0, 8'd4, 8'd3}, 32'hC0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram2buffer_input.md
Name: dram2buffer_input

Overview:
- Upstream loader for the double-banked input buffer. It accepts a valid/ready stream of 32-bit words and writes them into one bank, at consecutive addresses from a start address to an end address.
- On completion it pulses a done flag. The buffer-to-SRAM mover then uses the same start and end addresses to drain that bank into the input SRAMs.
- Ping-pong use: one bank is filled by this block while the other bank is being drained.

Parameters:
- DATA_W, 32, word width of the stream and of buffer data.
- BUF_AW, 7, per-bank buffer address width (128 entries per bank).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- load_start  input  1  one-cycle start request; sampled only in IDLE.
- BUF_ADDR_start  input  8  bit 7 selects the bank; bits 6:0 are the first word address.
- BUF_ADDR_end  input  8  bits 6:0 are the last word address; bit 7 is ignored.
- load_done  output  1  one-cycle pulse after the last word is committed.
- busy  output  1  high from the cycle after an accepted load_start until load_done inclusive.
- data_in  input  DATA_W  stream data.
- data_in_valid  input  1  stream valid.
- data_in_ready  output  1  stream ready.
- input_buffer_DI  output  DATA_W x [0:1]  per-bank write data.
- input_buffer_A_write  output  BUF_AW x [0:1]  per-bank write address.
- input_buffer_CEN_write  output  1 x [0:1]  per-bank chip enable, active-low.
- input_buffer_WEN  output  1 x [0:1]  per-bank write enable, active-low.

Behaviour:
- Reset values (also on rst asserted mid-load, taking effect at the next edge):
  - state IDLE; load_done=0, busy=0, data_in_ready=0.
  - CEN and WEN =1 on both banks; A=0 and DI=0 on both banks.
  - Any partially written data is abandoned; no done pulse is produced.
- Latching: in IDLE, load_start=1 latches bank = BUF_ADDR_start[7], addr = BUF_ADDR_start[6:0], end = BUF_ADDR_end[6:0], then moves to LOAD. Inputs may change afterwards.
- States:
  - IDLE: load_start -> LOAD; otherwise stay.
  - LOAD: data_in_ready=1 (combinational from state only). A beat is accepted when data_in_valid && data_in_ready.
    - Each accepted beat registers DI[bank]=data_in, A_write[bank]=addr, CEN[bank]=0, WEN[bank]=0 for exactly the next cycle.
    - Then addr <= addr+1, modulo 128.
    - If the accepted beat had addr == end -> FLUSH; otherwise stay in LOAD.
    - No accepted beat -> strobes high next cycle, addr unchanged (bubbles allowed).
  - FLUSH: data_in_ready=0; the last write strobe is active this cycle; -> DONE.
  - DONE: load_done=1 for this cycle only; strobes high; -> IDLE.
- Latency: a beat accepted at edge N is written by the strobe active in cycle N+1. For the last beat accepted at edge N, load_done is high in cycle N+2.
- Word count = ((end - start) mod 128) + 1.
  - start == end -> exactly 1 word.
  - end < start -> address wraps 127 -> 0 and continues up to end (e.g. start 126, end 1 -> 4 words).
- Non-selected bank: CEN=1 and WEN=1 at all times; its A and DI hold their values.
- busy=1 in LOAD, FLUSH and DONE.
- load_start outside IDLE is ignored, including in the DONE cycle.
- data_in and data_in_valid are ignored outside LOAD.
- A and DI hold their last values when the strobes deassert; they are not cleared.

Test Plan:
- Bank 0 basic: BUF_ADDR_start=8'h00, end=8'h03, valid held high with data 0xA0..0xA3.
  - Required: ready high 4 cycles.
  - Required: bank0 writes addr 0..3 with data A0..A3 on consecutive cycles.
  - Required: load_done 2 cycles after the last accept; bank1 strobes stay 1.
- Bank 1 with bubbles: start=8'h8A, end=8'h8C, valid toggling 1,0,1,0,1.
  - Required: writes to bank1 addr 10,11,12 only in cycles after a valid beat.
  - Required: 3 writes total; load_done once.
- Wrap: start=8'h7E, end=8'h01.
  - Required: 4 writes at addr 126, 127, 0, 1, then load_done.
- Single word: start=end=8'h05.
  - Required: one write to bank0 addr 5; ready high 1 cycle; busy high 3 cycles.
- Ignore and reset:
  - Stimulus: load_start re-pulsed during LOAD -> required: no relatch, addresses continue.
  - Stimulus: rst asserted after 2 of 8 beats -> required: next cycle all CEN/WEN=1, ready=0, busy=0, no load_done.
  - Stimulus: a new load afterwards -> required: runs from its own start address.
